// File: rtl/sensor_bus_arbiter.sv
// Round-robin arbiter giving four requesters shared access to one serial read engine.
// Each transaction: issue strobe, wait for Done (with timeout), one-cycle response, then a guard gap.
module sensor_bus_arbiter #(
  parameter int GUARD_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  Req,
  input  logic [31:0] ReqAddr,
  input  logic        Done,
  input  logic [7:0]  RecData,
  output logic        StartReading,
  output logic [7:0]  FirstByte,
  output logic [3:0]  Grant,
  output logic [3:0]  RspValid,
  output logic [7:0]  RspData,
  output logic        RspError,
  output logic        Busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    CAPTURE   = 3'd3,
    GUARD     = 3'd4
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GUARD_LAST   = 16'(GUARD_CYCLES - 1);

  state_t      state, state_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic [1:0]  win;
  logic [15:0] timeout_cnt, timeout_cnt_nxt;
  logic [15:0] guard_cnt, guard_cnt_nxt;
  logic        start_nxt;
  logic [7:0]  first_nxt;
  logic [3:0]  grant_nxt;
  logic [3:0]  rsp_valid_nxt;
  logic [7:0]  rsp_data_nxt;
  logic        rsp_error_nxt;
  logic        busy_nxt;

  // Search starts one past the last winner, so the last winner has lowest priority.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign win = rr_pick(Req, ptr);

  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    timeout_cnt_nxt = timeout_cnt;
    guard_cnt_nxt   = guard_cnt;
    start_nxt       = 1'b0;
    first_nxt       = FirstByte;
    grant_nxt       = Grant;
    rsp_valid_nxt   = 4'b0000;
    rsp_data_nxt    = RspData;
    rsp_error_nxt   = RspError;

    case (state)
      IDLE: begin
        if (|Req) begin
          ptr_nxt   = win;
          grant_nxt = 4'b0001 << win;
          first_nxt = ReqAddr[{win, 3'b000} +: 8];
          start_nxt = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        timeout_cnt_nxt = 16'd0;
        state_nxt       = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Done is checked first so a completion on the terminal cycle is not an error.
        if (Done) begin
          rsp_valid_nxt = Grant;
          rsp_data_nxt  = RecData;
          rsp_error_nxt = 1'b0;
          state_nxt     = CAPTURE;
        end else if (timeout_cnt == TIMEOUT_LAST) begin
          rsp_valid_nxt = Grant;
          rsp_data_nxt  = 8'h00;
          rsp_error_nxt = 1'b1;
          state_nxt     = CAPTURE;
        end else begin
          timeout_cnt_nxt = timeout_cnt + 16'd1;
        end
      end
      CAPTURE: begin
        grant_nxt     = 4'b0000;
        guard_cnt_nxt = 16'd0;
        state_nxt     = GUARD;
      end
      GUARD: begin
        if (guard_cnt == GUARD_LAST) begin
          state_nxt = IDLE;
        end else begin
          guard_cnt_nxt = guard_cnt + 16'd1;
        end
      end
      default: begin
        state_nxt       = IDLE;
        timeout_cnt_nxt = 16'd0;
        guard_cnt_nxt   = 16'd0;
        first_nxt       = 8'h00;
        grant_nxt       = 4'b0000;
        rsp_data_nxt    = 8'h00;
        rsp_error_nxt   = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      ptr          <= 2'd3;
      timeout_cnt  <= 16'd0;
      guard_cnt    <= 16'd0;
      StartReading <= 1'b0;
      FirstByte    <= 8'h00;
      Grant        <= 4'b0000;
      RspValid     <= 4'b0000;
      RspData      <= 8'h00;
      RspError     <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      timeout_cnt  <= timeout_cnt_nxt;
      guard_cnt    <= guard_cnt_nxt;
      StartReading <= start_nxt;
      FirstByte    <= first_nxt;
      Grant        <= grant_nxt;
      RspValid     <= rsp_valid_nxt;
      RspData      <= rsp_data_nxt;
      RspError     <= rsp_error_nxt;
      Busy         <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_sensor_bus_arbiter.sv
// Directed bench for sensor_bus_arbiter: single request, rotation, timeout,
// withdrawal/address change, stray Done and mid-transaction reset.
module tb_sensor_bus_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Req = 4'b0000;
  logic [31:0] ReqAddr = 32'h0;
  logic        Done = 1'b0;
  logic [7:0]  RecData = 8'h00;
  logic        StartReading;
  logic [7:0]  FirstByte;
  logic [3:0]  Grant;
  logic [3:0]  RspValid;
  logic [7:0]  RspData;
  logic        RspError;
  logic        Busy;

  int checks   = 0;
  int failures = 0;

  sensor_bus_arbiter #(.GUARD_CYCLES(16), .TIMEOUT_CYCLES(8)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .ReqAddr(ReqAddr), .Done(Done),
    .RecData(RecData), .StartReading(StartReading), .FirstByte(FirstByte),
    .Grant(Grant), .RspValid(RspValid), .RspData(RspData), .RspError(RspError),
    .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one complete transaction from IDLE through the end of GUARD.
  task automatic run_txn(input string tag, input logic [3:0] exp_g, input logic [7:0] exp_fb,
                         input logic [3:0] req_after, input logic [31:0] addr_after,
                         input logic done_in_issue, input int done_at, input logic [7:0] rdata,
                         input int exp_lat, input logic [7:0] exp_rd, input logic exp_err);
    int n;
    n = 0;
    while (!StartReading && n < 40) begin
      tick();
      n++;
    end
    chk({tag, ".start"}, 32'(StartReading), 32'h1);
    chk({tag, ".grant"}, 32'(Grant), 32'(exp_g));
    chk({tag, ".first"}, 32'(FirstByte), 32'(exp_fb));
    chk({tag, ".busy"}, 32'(Busy), 32'h1);
    Req     = req_after;
    ReqAddr = addr_after;
    Done    = done_in_issue;
    RecData = rdata;
    tick();
    chk({tag, ".start_pulse"}, 32'(StartReading), 32'h0);
    n = 0;
    while (RspValid == 4'b0000 && n < 20) begin
      Done = (n == done_at);
      tick();
      n++;
    end
    Done = 1'b0;
    chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
    chk({tag, ".rsp_valid"}, 32'(RspValid), 32'(exp_g));
    chk({tag, ".rsp_data"}, 32'(RspData), 32'(exp_rd));
    chk({tag, ".rsp_error"}, 32'(RspError), 32'(exp_err));
    chk({tag, ".hold"}, 32'({Grant, FirstByte}), 32'({exp_g, exp_fb}));
    tick();
    chk({tag, ".guard_entry"}, 32'({Grant, RspValid, Busy}), 32'h001);
    repeat (15) tick();
    chk({tag, ".guard_last"}, 32'({Busy, StartReading}), 32'h2);
    tick();
    chk({tag, ".idle"}, 32'(Busy), 32'h0);
  endtask

  initial begin
    // Reset state
    Reset = 1'b1;
    tick();
    tick();
    chk("reset_outputs", 32'({StartReading, FirstByte, Grant, RspValid, RspData, RspError, Busy}), 32'h0);
    Reset = 1'b0;
    tick();
    chk("idle_no_req", 32'({Busy, StartReading}), 32'h0);

    // Single request from requester 0
    Req     = 4'b0001;
    ReqAddr = 32'h0000_0091;
    run_txn("single", 4'b0001, 8'h91, 4'b0000, 32'h0000_0091, 1'b0, 2, 8'h1A, 3, 8'h1A, 1'b0);

    // Round-robin with all four requesting, after a fresh reset
    Reset = 1'b1;
    tick();
    Reset   = 1'b0;
    Req     = 4'b1111;
    ReqAddr = 32'hD4C3_B2A1;
    run_txn("rr0", 4'b0001, 8'hA1, 4'b1111, 32'hD4C3_B2A1, 1'b0, 0, 8'h10, 1, 8'h10, 1'b0);
    run_txn("rr1", 4'b0010, 8'hB2, 4'b1111, 32'hD4C3_B2A1, 1'b0, 1, 8'h21, 2, 8'h21, 1'b0);
    run_txn("rr2", 4'b0100, 8'hC3, 4'b1111, 32'hD4C3_B2A1, 1'b0, 0, 8'h32, 1, 8'h32, 1'b0);
    run_txn("rr3", 4'b1000, 8'hD4, 4'b1111, 32'hD4C3_B2A1, 1'b0, 3, 8'h43, 4, 8'h43, 1'b0);
    run_txn("rr4", 4'b0001, 8'hA1, 4'b0000, 32'hD4C3_B2A1, 1'b0, 0, 8'h54, 1, 8'h54, 1'b0);

    // Timeout with no Done, then Done on the terminal cycle
    Req     = 4'b0001;
    ReqAddr = 32'h0000_00C5;
    run_txn("timeout", 4'b0001, 8'hC5, 4'b0000, 32'h0000_00C5, 1'b0, -1, 8'hFF, 8, 8'h00, 1'b1);
    Req = 4'b0001;
    run_txn("late_done", 4'b0001, 8'hC5, 4'b0000, 32'h0000_00C5, 1'b0, 7, 8'h5C, 8, 8'h5C, 1'b0);

    // Stray Done while idle
    Done    = 1'b1;
    RecData = 8'hFF;
    tick();
    tick();
    chk("idle_done_ignored", 32'({RspValid, Busy, StartReading}), 32'h0);
    Done = 1'b0;

    // Withdrawal, address change and Done during ISSUE
    Req     = 4'b0100;
    ReqAddr = 32'h0077_0000;
    run_txn("withdraw", 4'b0100, 8'h77, 4'b0000, 32'h00EE_0000, 1'b1, 2, 8'h3D, 3, 8'h3D, 1'b0);

    // Reset in the middle of WAIT_DONE
    Req     = 4'b0001;
    ReqAddr = 32'h0000_4211;
    tick();
    chk("mid_start", 32'({StartReading, Grant}), 32'h11);
    Req = 4'b0000;
    tick();
    tick();
    Reset = 1'b1;
    Done  = 1'b1;
    tick();
    chk("mid_reset_outputs", 32'({StartReading, FirstByte, Grant, RspValid, RspData, RspError, Busy}), 32'h0);
    Reset = 1'b0;
    Done  = 1'b0;
    Req   = 4'b1010;
    tick();
    chk("post_reset_no_rsp", 32'(RspValid), 32'h0);
    run_txn("post_reset", 4'b0010, 8'h42, 4'b0000, 32'h0000_4211, 1'b0, 1, 8'h6E, 2, 8'h6E, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
